// File: rtl/routing_pkg.sv
// Shared types and widths for the routing lookup arbiter: FSM states,
// default engine latency and response field widths.
package routing_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        INIT  = 2'd2
    } arb_state_t;

    localparam int ENG_LAT_DEFAULT = 3;
    localparam int IP_WIDTH        = 32;
    localparam int PORT_WIDTH      = 16;
    localparam int QP_WIDTH        = 16;
endpackage

// File: rtl/routing_lookup_arbiter_if.sv
// Requester-side and engine-side buses of the routing lookup arbiter.
// slave is the arbiter's view; master is the requesters/engine environment.
interface routing_lookup_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import routing_pkg::*;

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*IP_WIDTH-1:0] req_dst_ip;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic                        rsp_found;
    logic [PORT_WIDTH-1:0]       rsp_out_port;
    logic [QP_WIDTH-1:0]         rsp_out_qp;
    logic [IP_WIDTH-1:0]         rsp_next_hop_ip;

    logic                        eng_lookup_valid;
    logic [IP_WIDTH-1:0]         eng_lookup_dst_ip;
    logic                        eng_resp_valid;
    logic                        eng_resp_found;
    logic [PORT_WIDTH-1:0]       eng_resp_out_port;
    logic [QP_WIDTH-1:0]         eng_resp_out_qp;
    logic [IP_WIDTH-1:0]         eng_resp_next_hop_ip;
    logic                        eng_init_mode;

    modport master (
        output req_valid, req_dst_ip,
        output eng_resp_valid, eng_resp_found, eng_resp_out_port, eng_resp_out_qp, eng_resp_next_hop_ip,
        input  req_ready, rsp_valid, rsp_found, rsp_out_port, rsp_out_qp, rsp_next_hop_ip,
        input  eng_lookup_valid, eng_lookup_dst_ip, eng_init_mode
    );

    modport slave (
        input  req_valid, req_dst_ip,
        input  eng_resp_valid, eng_resp_found, eng_resp_out_port, eng_resp_out_qp, eng_resp_next_hop_ip,
        output req_ready, rsp_valid, rsp_found, rsp_out_port, rsp_out_qp, rsp_next_hop_ip,
        output eng_lookup_valid, eng_lookup_dst_ip, eng_init_mode
    );
endinterface

// File: rtl/rr_arbiter.sv
// Single-cycle round-robin arbiter; the priority pointer moves past the
// granted index only when advance is asserted.
module rr_arbiter
    import routing_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);
    logic [IDX_W-1:0]   ptr_reg;
    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper_req;
    logic [NUM_REQ-1:0] pick_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign upper_mask[gi] = (IDX_W'(gi) >= ptr_reg);
        end
    endgenerate

    // Requests at or above the pointer win; otherwise wrap to the lowest index.
    assign upper_req = req & upper_mask;
    assign pick_vec  = (|upper_req) ? upper_req : req;

    always_comb begin
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pick_vec[k]) begin
                grant_idx = k[IDX_W-1:0];
            end
        end
        grant = '0;
        if (en && (|req)) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/routing_lookup_arbiter.sv
// Arbitrates requester lookups onto one routing engine, tracks in-flight tags
// and handles the drain/init handshake. ROUTE_ARB_STATS_EN adds grant/miss counters.
module routing_lookup_arbiter
    import routing_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ENG_LAT = ENG_LAT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    routing_lookup_arbiter_if.slave   bus,
    input  logic                      cfg_init_req,
    output logic                      cfg_init_ack,
    output logic                      err_orphan
`ifdef ROUTE_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [NUM_REQ*32-1:0]     stat_grant_cnt,
    output logic [31:0]               stat_miss_cnt
`endif
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t          state_reg, state_next;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_en, accept;
    logic [IP_WIDTH-1:0] req_ip [NUM_REQ];

    logic                tag_valid_reg [ENG_LAT];
    logic [IDX_W-1:0]    tag_idx_reg   [ENG_LAT];
    logic                tags_empty, last_valid, deliver;
    logic [IDX_W-1:0]    last_idx;

    logic [NUM_REQ-1:0]    rsp_valid_reg;
    logic                  rsp_found_reg;
    logic [PORT_WIDTH-1:0] rsp_out_port_reg;
    logic [QP_WIDTH-1:0]   rsp_out_qp_reg;
    logic [IP_WIDTH-1:0]   rsp_next_hop_ip_reg;
    logic                  err_orphan_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ip
            assign req_ip[gi] = bus.req_dst_ip[gi*IP_WIDTH +: IP_WIDTH];
        end
    endgenerate

    // A pending init request beats any same-cycle lookup request.
    assign grant_en = (state_reg == RUN) && !cfg_init_req && !rst;
    assign accept   = |grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .en        (grant_en),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.req_ready         = grant;
    assign bus.eng_lookup_valid  = accept;
    assign bus.eng_lookup_dst_ip = accept ? req_ip[grant_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ENG_LAT; k++) begin
                tag_valid_reg[k] <= 1'b0;
                tag_idx_reg[k]   <= '0;
            end
        end else begin
            tag_valid_reg[0] <= accept;
            tag_idx_reg[0]   <= grant_idx;
            for (int k = 1; k < ENG_LAT; k++) begin
                tag_valid_reg[k] <= tag_valid_reg[k-1];
                tag_idx_reg[k]   <= tag_idx_reg[k-1];
            end
        end
    end

    always_comb begin
        tags_empty = 1'b1;
        for (int k = 0; k < ENG_LAT; k++) begin
            if (tag_valid_reg[k]) begin
                tags_empty = 1'b0;
            end
        end
    end

    assign last_valid = tag_valid_reg[ENG_LAT-1];
    assign last_idx   = tag_idx_reg[ENG_LAT-1];
    assign deliver    = bus.eng_resp_valid && last_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (cfg_init_req) state_next = DRAIN;
            DRAIN:   if (tags_empty)   state_next = INIT;
            INIT:    if (!cfg_init_req) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // A response without a tag, or a tag without a response, is an orphan.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg       <= '0;
            rsp_found_reg       <= 1'b0;
            rsp_out_port_reg    <= '0;
            rsp_out_qp_reg      <= '0;
            rsp_next_hop_ip_reg <= '0;
            err_orphan_reg      <= 1'b0;
        end else begin
            rsp_valid_reg <= '0;
            if (deliver) begin
                rsp_valid_reg[last_idx] <= 1'b1;
                rsp_found_reg           <= bus.eng_resp_found;
                rsp_out_port_reg        <= bus.eng_resp_out_port;
                rsp_out_qp_reg          <= bus.eng_resp_out_qp;
                rsp_next_hop_ip_reg     <= bus.eng_resp_next_hop_ip;
            end
            if (bus.eng_resp_valid != last_valid) begin
                err_orphan_reg <= 1'b1;
            end
        end
    end

    assign bus.rsp_valid       = rst ? '0 : rsp_valid_reg;
    assign bus.rsp_found       = rsp_found_reg && !rst;
    assign bus.rsp_out_port    = rst ? '0 : rsp_out_port_reg;
    assign bus.rsp_out_qp      = rst ? '0 : rsp_out_qp_reg;
    assign bus.rsp_next_hop_ip = rst ? '0 : rsp_next_hop_ip_reg;
    assign bus.eng_init_mode   = (state_reg == INIT) && !rst;
    assign cfg_init_ack        = (state_reg == INIT) && !rst;
    assign err_orphan          = err_orphan_reg && !rst;

`ifdef ROUTE_ARB_STATS_EN
    logic [31:0] grant_cnt_reg [NUM_REQ];
    logic [31:0] miss_cnt_reg;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            always_ff @(posedge clk) begin
                if (rst || stat_clr) begin
                    grant_cnt_reg[gi] <= '0;
                end else if (grant[gi] && (grant_cnt_reg[gi] != 32'hFFFF_FFFF)) begin
                    grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 32'd1;
                end
            end
            assign stat_grant_cnt[gi*32 +: 32] = rst ? '0 : grant_cnt_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            miss_cnt_reg <= '0;
        end else if (deliver && !bus.eng_resp_found && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end
    assign stat_miss_cnt = rst ? '0 : miss_cnt_reg;
`endif
endmodule

// File: tb/tb_routing_lookup_arbiter.sv
// Randomised scoreboard bench for routing_lookup_arbiter with a fixed-latency
// engine model and a transaction-level reference model of arbitration and init.
module tb_routing_lookup_arbiter;
    import routing_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_init_req = 1'b0;
    logic cfg_init_ack, err_orphan;
    logic [N-1:0]    req_v   = '0;
    logic [N*32-1:0] ip_flat = '0;
    logic inject = 1'b0;
    int cyc = 0;
    int n_pass = 0;
    int n_checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    routing_lookup_arbiter_if #(.NUM_REQ(N)) bus ();

`ifdef ROUTE_ARB_STATS_EN
    logic stat_clr = 1'b0;
    logic [N*32-1:0] stat_grant_cnt;
    logic [31:0]     stat_miss_cnt;
`endif

    routing_lookup_arbiter #(.NUM_REQ(N), .ENG_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cfg_init_req (cfg_init_req),
        .cfg_init_ack (cfg_init_ack),
        .err_orphan   (err_orphan)
`ifdef ROUTE_ARB_STATS_EN
        ,
        .stat_clr       (stat_clr),
        .stat_grant_cnt (stat_grant_cnt),
        .stat_miss_cnt  (stat_miss_cnt)
`endif
    );

    // Routing table: {found, out_port, out_qp, next_hop}; 10.0.0.5 -> found, port 3.
    function automatic logic [64:0] route(input logic [31:0] ip);
        logic found;
        found = (ip[7:6] != 2'b11);
        return {found, ip[15:0] - 16'd2, ip[31:16] ^ 16'h00FF, ip + 32'd1};
    endfunction

    // Engine model: answers every lookup exactly LAT cycles later.
    logic [LAT-1:0] e_v = '0;
    logic [31:0]    e_ip [LAT] = '{default: '0};
    logic [64:0]    e_rsp;
    always @(posedge clk) begin
        if (rst) e_v <= '0;
        else     e_v <= {e_v[LAT-2:0], bus.eng_lookup_valid};
        e_ip[0] <= bus.eng_lookup_dst_ip;
        for (int k = 1; k < LAT; k++) e_ip[k] <= e_ip[k-1];
    end
    assign e_rsp                    = route(e_ip[LAT-1]);
    assign bus.eng_resp_valid       = e_v[LAT-1] | inject;
    assign bus.eng_resp_found       = e_rsp[64];
    assign bus.eng_resp_out_port    = e_rsp[63:48];
    assign bus.eng_resp_out_qp      = e_rsp[47:32];
    assign bus.eng_resp_next_hop_ip = e_rsp[31:0];
    assign bus.req_valid            = req_v;
    assign bus.req_dst_ip           = ip_flat;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] ip;
    } exp_t;
    exp_t sbq[$];

    int   m_mode = 0;       // 0 run, 1 drain, 2 init
    int   m_ptr = 0;
    int   m_last_acc = -100;
    logic exp_orphan = 1'b0;

    // Reference model: predicts grants and mode each cycle, queues expected responses.
    always @(negedge clk) begin : model
        logic [N-1:0] eg;
        int g;
        logic tag_last;
        if (rst) begin
            chk("reset_outputs", {bus.req_ready, bus.eng_lookup_valid, bus.eng_init_mode,
                                  cfg_init_ack, err_orphan, bus.rsp_valid}, '0);
            sbq.delete();
            m_mode = 0; m_ptr = 0; m_last_acc = -100; exp_orphan = 1'b0;
        end else begin
            eg = '0;
            g  = -1;
            if (m_mode == 0 && !cfg_init_req)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) eg[g] = 1'b1;
            chk("req_ready", bus.req_ready, eg);
            chk("lookup_valid", bus.eng_lookup_valid, g >= 0);
            if (g >= 0) chk("lookup_ip", bus.eng_lookup_dst_ip, ip_flat[32*g +: 32]);
            chk("init_mode_ack", {bus.eng_init_mode, cfg_init_ack}, (m_mode == 2) ? 2'b11 : 2'b00);
            chk("err_orphan", err_orphan, exp_orphan);
            tag_last = 1'b0;
            foreach (sbq[i]) if (sbq[i].due == cyc + 1) tag_last = 1'b1;
            if (inject && !tag_last) exp_orphan = 1'b1;
            if (g >= 0) begin
                sbq.push_back('{due: cyc + LAT + 1, idx: g, ip: ip_flat[32*g +: 32]});
                m_ptr = (g + 1) % N;
                m_last_acc = cyc;
            end
            case (m_mode)
                0:       if (cfg_init_req) m_mode = 1;
                1:       if (cyc > m_last_acc + LAT) m_mode = 2;
                default: if (!cfg_init_req) m_mode = 0;
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (bus.rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, '0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_latency", cyc, e.due);
                    chk("rsp_index", bus.rsp_valid, N'(1) << e.idx);
                    chk("rsp_fields", {bus.rsp_found, bus.rsp_out_port, bus.rsp_out_qp,
                                       bus.rsp_next_hop_ip}, route(e.ip));
                    $display("rsp req=%0d ip=%h port=%0d t=%0d", e.idx, e.ip, bus.rsp_out_port, cyc);
                end
            end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                chk("rsp_missing", bus.rsp_valid, N'(1) << e.idx);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ip(input int i, input logic [31:0] v);
        ip_flat[32*i +: 32] = v;
    endtask

    task automatic wait_init();
        int t;
        t = 0;
        while (bus.eng_init_mode !== 1'b1 && t < 30) begin
            step(1);
            t++;
        end
        chk("init_reached", bus.eng_init_mode, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);

        // All four requesters held for 8 cycles
        for (int i = 0; i < N; i++) set_ip(i, {8'd10, 8'd1, 8'd0, 8'(i + 1)});
        req_v = '1;
        step(8);
        req_v = '0;
        step(6);

        // Single lookup of 10.0.0.5
        set_ip(0, 32'h0A00_0005);
        req_v = 4'b0001;
        step(1);
        req_v = '0;
        step(6);

        // Three grants, then init request while requests stay pending
        req_v = 4'b1111;
        step(3);
        cfg_init_req = 1'b1;
        step(2);
        wait_init();
        step(3);
        req_v = 4'b0100;
        cfg_init_req = 1'b0;
        step(2);
        req_v = '0;
        step(6);

        // Init request pulsed while lookups drain
        req_v = 4'b0011;
        step(2);
        req_v = '0;
        cfg_init_req = 1'b1;
        step(1);
        cfg_init_req = 1'b0;
        step(10);

        // Randomised traffic with occasional init requests
        for (int c = 0; c < 300; c++) begin
            req_v = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) set_ip(i, $urandom);
            if (cfg_init_req) cfg_init_req = ($urandom_range(0, 3) != 0);
            else              cfg_init_req = ($urandom_range(0, 39) == 0);
            step(1);
        end
        req_v = '0;
        cfg_init_req = 1'b0;
        step(10);

        // Engine response with nothing in flight
        inject = 1'b1;
        step(1);
        inject = 1'b0;
        step(3);

        // Reset with two lookups in flight
        req_v = 4'b1000;
        step(2);
        req_v = '0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(8);

`ifdef ROUTE_ARB_STATS_EN
        stat_clr = 1'b1;
        step(1);
        stat_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_ip(1, (k < 2) ? 32'h0A00_00C1 : 32'h0A00_0011);
            req_v = 4'b0010;
            step(1);
        end
        req_v = '0;
        step(8);
        chk("stat_grant1", stat_grant_cnt[63:32], 32'd5);
        chk("stat_grant0", stat_grant_cnt[31:0], 32'd0);
        chk("stat_miss", stat_miss_cnt, 32'd2);
        stat_clr = 1'b1;
        step(1);
        stat_clr = 1'b0;
        chk("stat_clr_grant1", stat_grant_cnt[63:32], 32'd0);
        chk("stat_clr_miss", stat_miss_cnt, 32'd0);
`endif

        for (int t = 0; t < 40 && sbq.size() != 0; t++) step(1);
        step(2);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/routing_lookup_arbiter.md
ROUTING_LOOKUP_ARBITER -- requirements
Module: routing_lookup_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of lookup requesters (2..8).
REQ-002 The block SHALL have parameter ENG_LAT, default 3, giving the routing engine lookup-to-response latency in cycles.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-004 The block SHALL have these requester-side ports:
- req_valid  in  NUM_REQ  per-requester lookup request
- req_dst_ip  in  NUM_REQ*32  destination IPs, requester i at [32i+31:32i]
- req_ready  out  NUM_REQ  one-hot grant; the request is accepted when valid and ready are both high
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_found, rsp_out_port[16], rsp_out_qp[16], rsp_next_hop_ip[32]  out  shared response fields
REQ-005 The block SHALL have these engine-side ports:
- eng_lookup_valid  out  1
- eng_lookup_dst_ip  out  32
- eng_resp_valid, eng_resp_found  in  1
- eng_resp_out_port[16], eng_resp_out_qp[16], eng_resp_next_hop_ip[32]  in
- eng_init_mode  out  1  drives the engine's initialisation mode
REQ-006 The block SHALL have these configuration-handshake ports: cfg_init_req  in  1  (level); cfg_init_ack  out  1; err_orphan  out  1  (sticky).

Function
REQ-007 The block SHALL implement the state machine RUN -> DRAIN -> INIT -> RUN.
REQ-008 In RUN, with any req_valid high and cfg_init_req low, the block SHALL grant exactly one requester round-robin in the same cycle, combinationally: eng_lookup_valid=1, eng_lookup_dst_ip = the granted requester's IP, req_ready = the grant.
REQ-009 The round-robin pointer SHALL advance to grant index +1, modulo NUM_REQ, only on a grant; highest priority starts at index 0 after reset.
REQ-010 A tag pipeline of ENG_LAT stages {valid, index} SHALL shift every cycle, loading the grant index on acceptance and an invalid entry otherwise.
REQ-011 When eng_resp_valid is high and the last tag stage is valid, the block SHALL register the response, setting rsp_valid[index]=1 and the data fields one cycle later; total latency from acceptance to rsp_valid is ENG_LAT+1 cycles, and back-to-back acceptance SHALL be supported every cycle.
REQ-012 When eng_resp_valid is high and the last tag stage is invalid, the block SHALL set err_orphan and SHALL NOT assert any rsp_valid bit.
REQ-013 When the last tag stage is valid without eng_resp_valid, the block SHALL drop the tag and set err_orphan.
REQ-014 When cfg_init_req is high in RUN, the block SHALL move to DRAIN and issue no grant in that cycle; init takes priority over a simultaneous req_valid.
REQ-015 In DRAIN, grants SHALL be blocked, and the block SHALL enter INIT in the cycle after all tag stages are invalid.
REQ-016 In INIT, eng_init_mode and cfg_init_ack SHALL be 1 and grants SHALL be blocked.
REQ-017 When cfg_init_req falls, the block SHALL return to RUN on the next cycle with eng_init_mode=0.
REQ-018 If cfg_init_req falls during DRAIN, the block SHALL still complete the drain, pass through INIT for one cycle, then return to RUN.

Reset
REQ-019 On reset the block SHALL enter state RUN, clear all tags (in-flight lookups are discarded and produce no rsp_valid), and set the RR pointer to 0.
REQ-020 During reset all outputs SHALL be 0, including req_ready, rsp_*, eng_lookup_valid, eng_init_mode, cfg_init_ack and err_orphan.

Configuration
REQ-021 With macro ROUTE_ARB_STATS_EN defined, the block SHALL add ports stat_clr in 1, stat_grant_cnt out NUM_REQ*32 and stat_miss_cnt out 32.
REQ-022 With ROUTE_ARB_STATS_EN defined, the counters SHALL saturate at 32'hFFFFFFFF, clear on rst or stat_clr (stat_clr wins over a same-cycle increment), and count grants per requester and delivered responses with found=0.
REQ-023 Without ROUTE_ARB_STATS_EN, the ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-024 Shared package routing_pkg SHALL hold the arb_state_t enum (RUN, DRAIN, INIT), ENG_LAT_DEFAULT=3, IP_WIDTH=32 and the response-field widths.
REQ-025 The round-robin grant logic SHALL be a sub-module rr_arbiter, with inputs req[NUM_REQ], en and advance, and outputs grant[NUM_REQ] and grant_idx.

Verification
REQ-026 Bench scenario: req_valid=4'b0001, IP 10.0.0.5, with the engine model returning found=1, out_port=3 -> req_ready[0] in cycle T, rsp_valid=4'b0001 at T+4, rsp_out_port=3.
REQ-027 Bench scenario: all four requesters held valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 on consecutive cycles, and responses return in the same order at latency 4.
REQ-028 Bench scenario: cfg_init_req raised one cycle after 3 back-to-back grants -> no further grants, all 3 responses delivered, eng_init_mode=1 and cfg_init_ack=1 starting the cycle after the last tag clears.
REQ-029 Bench scenario: cfg_init_req dropped in INIT while req_valid[2]=1 -> eng_init_mode=0 and req_ready[2]=1 on the next cycle.
REQ-030 Bench scenario: eng_resp_valid injected with no lookup in flight -> err_orphan=1 and rsp_valid stays 0; rst asserted with 2 lookups in flight -> no rsp_valid after reset.
REQ-031 Bench scenario, with ROUTE_ARB_STATS_EN defined: 5 grants to requester 1 with 2 misses -> stat_grant_cnt[1]=5 and stat_miss_cnt=2; after stat_clr both read 0.
